// File: rtl/kpn_pkg.sv
// Shared KPN channel definitions: token width, the null-token value and the
// reader's buffer-occupancy state encoding.
// Used by the channel FIFO and by the consumer-side reader.
package kpn_pkg;

  localparam int TOKEN_W = 16;
  localparam logic [TOKEN_W-1:0] TOKEN_NULL = '0;

  // Number of tokens held in the reader's 2-entry prefetch buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/kpn_skid_buf2.sv
// 2-entry register buffer with head/tail pointers; push writes the tail and pop advances the head.
// Latency: a pushed word is visible on head_dat_o in the cycle after the push.
// Backpressure: none internally. The caller must never push when full without also popping, and must never pop when empty.
// Ports: clk/rst_n; push_i + push_dat_i write the tail; pop_i retires the head;
//        head_dat_o is the oldest stored word; occ_o is the occupancy state.
module kpn_skid_buf2
  import kpn_pkg::*;
#(
  parameter int W = TOKEN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output occ_e         occ_o
);

  logic [W-1:0] mem_q [2];
  logic         head_q;
  logic         tail_q;
  occ_e         occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      occ_q    <= OCC_EMPTY;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_dat_i;
        tail_q        <= ~tail_q;
      end
      if (pop_i) begin
        head_q <= ~head_q;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
        2'b10: occ_q <= (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
        2'b01: occ_q <= (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_dat_o = mem_q[head_q];
  assign occ_o      = occ_q;

endmodule

// File: rtl/kpn_fifo_reader.sv
// KPN channel consumer: drains the channel FIFO through a 2-entry prefetch buffer and exposes the tokens on a valid/ready interface.
// Latency: fifo_rd to tok_valid takes 2 cycles; after the buffer fills, the reader sustains 1 token/cycle.
// Backpressure: reads stop once buffer plus in-flight words would exceed 2 entries; no token is ever dropped.
// Ports: FIFO side (fifo_empty, fifo_rdata, fifo_rd); downstream side (tok_valid,
//        tok_ready, tok_data); en gates new reads; tok_count/block_cycles are
//        saturating statistics.
module kpn_fifo_reader
  import kpn_pkg::*;
#(
  parameter int B         = TOKEN_W,
  parameter int CW        = 16,
  parameter int SKIP_ZERO = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [B-1:0]  fifo_rdata,
  output logic          fifo_rd,
  output logic          tok_valid,
  input  logic          tok_ready,
  output logic [B-1:0]  tok_data,
  output logic [CW-1:0] tok_count,
  output logic [CW-1:0] block_cycles
);

  occ_e          occ;
  logic [B-1:0]  head_dat;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] tok_count_q, tok_count_d;
  logic [CW-1:0] block_q, block_d;
  logic          pop, push, is_null, slot_ok;
  logic [2:0]    committed;

  kpn_skid_buf2 #(.W(B)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (fifo_rdata),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .occ_o      (occ)
  );

  assign tok_valid = (occ != OCC_EMPTY);
  assign tok_data  = head_dat;
  assign pop       = tok_valid && tok_ready;

  // Null words still occupy a read slot while in flight. They are simply never written into the buffer.
  assign is_null = (SKIP_ZERO != 0) && (fifo_rdata == B'(TOKEN_NULL));
  assign push    = inflight_q && !is_null;

  // A new read is allowed only if its data is guaranteed a free slot on return.
  // The slot count includes stored words and the in-flight word, minus any word leaving this cycle.
  assign committed = 3'(occ) + 3'(inflight_q);
  assign slot_ok   = committed < (3'd2 + 3'(pop));

  // Gating with rst_n forces the strobe low as soon as reset asserts.
  assign fifo_rd = rst_n && en && !fifo_empty && slot_ok;

  always_comb begin
    inflight_d  = fifo_rd;
    tok_count_d = tok_count_q;
    block_d     = block_q;
    if (pop && (tok_count_q != {CW{1'b1}})) begin
      tok_count_d = tok_count_q + CW'(1);
    end
    if (tok_ready && !tok_valid && fifo_empty && (block_q != {CW{1'b1}})) begin
      block_d = block_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q  <= 1'b0;
      tok_count_q <= '0;
      block_q     <= '0;
    end else begin
      inflight_q  <= inflight_d;
      tok_count_q <= tok_count_d;
      block_q     <= block_d;
    end
  end

  assign tok_count    = tok_count_q;
  assign block_cycles = block_q;

endmodule

// File: doc/kpn_fifo_reader.md
Name: kpn_fifo_reader

Overview:
- Consumer-side endpoint of a KPN channel. Drains tokens from the 16-bit channel FIFO through its rd/empty interface and presents them to a downstream process node on a valid/ready interface.
- Implements KPN blocking-read semantics. Hides the FIFO's 1-cycle read latency with a 2-entry prefetch buffer, so it sustains 1 token/cycle.
- Keeps token and blocked-cycle statistics for the host-side monitor.

Parameters:
- B, 16, token width in bits (matches channel FIFO word width)
- CW, 16, width of statistics counters
- SKIP_ZERO, 1, when 1, a token of value 0 is treated as a null word: discarded, not forwarded, not counted

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  read enable; when 0, no new FIFO reads are issued
- fifo_empty  input  1  channel FIFO empty flag
- fifo_rdata  input  B  channel FIFO read data; valid one cycle after fifo_rd
- fifo_rd  output  1  FIFO read strobe, one pop per cycle asserted
- tok_valid  output  1  token available to downstream
- tok_ready  input  1  downstream accepts token
- tok_data  output  B  token value
- tok_count  output  CW  tokens delivered (valid&&ready handshakes), saturating
- block_cycles  output  CW  cycles blocked: tok_ready=1, tok_valid=0, fifo_empty=1; saturating

Behaviour:
- Reset (async, rst_n=0): fifo_rd=0, tok_valid=0, tok_data=0, tok_count=0, block_cycles=0. Buffer occupancy=0, in-flight flag=0.
- Reset mid-operation discards buffered and in-flight tokens. The FIFO-side pop already performed is lost; this is by design.
- Occupancy state machine, tracking buffer entries: EMPTY(0), ONE(1), TWO(2).
- In-flight flag: set in the cycle after fifo_rd=1. A word is captured from fifo_rdata when the flag is 1.
- Read issue, combinational from registered state: fifo_rd = en && !fifo_empty && (occupancy + inflight + (capture this cycle ? 0 : 0) - pop_this_cycle < 2). Equivalently, a read is issued only if a free slot is guaranteed when the data returns.
- fifo_rd is never asserted while fifo_empty=1.
- Capture: when in-flight, fifo_rdata is written to the buffer tail, unless SKIP_ZERO=1 and fifo_rdata==0. In that case it is dropped and the slot is released.
- Output: tok_valid = occupancy!=0. tok_data = buffer head, registered storage only; no combinational path from fifo_rdata.
- Pop on tok_valid && tok_ready.
- Capture and pop in the same cycle: occupancy unchanged, head advances.
- Latency: FIFO non-empty with reader idle → fifo_rd same cycle → tok_valid 2 cycles after fifo_rd.
- Throughput: with tok_ready held 1 and FIFO non-empty, 1 token/cycle after fill.
- Backpressure: with tok_ready=0, at most 2 tokens are buffered. fifo_rd deasserts before overflow; no token is dropped or duplicated.
- en=0: no new reads. An in-flight word is still captured. Output handshakes continue.
- tok_data is held stable while tok_valid=1 and tok_ready=0.
- Counters: tok_count increments on each handshake. block_cycles increments per the port definition. Both saturate at 2^CW-1.
- FIFO order is preserved exactly.

Decomposition:
- Shared package kpn_pkg: token width constant TOKEN_W=16 and null-token constant TOKEN_NULL=0. The channel FIFO uses the same package.
- One sub-module, kpn_skid_buf2: 2-entry register buffer with head/tail pointers, push/pop, and occupancy. The parent holds read-issue logic, the in-flight flag, zero filtering and counters.

Test Plan:
- Fill FIFO model with 0x0001..0x0005, tok_ready=1, en=1 → fifo_rd asserts 5 consecutive cycles; tok_data 0x0001..0x0005 on consecutive cycles starting 2 cycles after first fifo_rd; tok_count=5.
- FIFO holds 0x00A0..0x00A5, tok_ready=0 for 10 cycles → exactly 2 fifo_rd pulses, tok_data=0x00A0 held stable. Release tok_ready → all 6 delivered in order, none lost or duplicated.
- SKIP_ZERO=1, FIFO sequence 0x0003, 0x0000, 0x0007 → downstream sees 0x0003 then 0x0007; tok_count=2.
- FIFO empty, tok_ready=1 for 8 cycles → fifo_rd never asserts, tok_valid=0, block_cycles=8. Then push 0x0009 → delivered; block_cycles stops incrementing.
- en dropped in the same cycle as a fifo_rd → in-flight word 0x0011 still delivered; no further fifo_rd while en=0.
- Assert rst_n=0 asynchronously with 2 tokens buffered → tok_valid, fifo_rd and counters go to 0 immediately, without waiting for a clk edge. After release, the next FIFO word is delivered normally.
